// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared types and defaults for the execute-stage branch resolution logic.
//   bru_state_t       : recovery FSM state (IDLE / RECOVER)
//   CNT_WIDTH_DEFAULT : default width of the performance counters
//   DATA_WIDTH_DEFAULT: default address/data width
// -----------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bru_state_t;

  localparam int unsigned CNT_WIDTH_DEFAULT  = 32'd16;
  localparam int unsigned DATA_WIDTH_DEFAULT = 32'd32;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   count : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 32'd16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: increments on inc until all-ones, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + WIDTH'(1'b1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Carries the decode-stage static prediction into execute, compares it with the
// resolved condition and, on a mismatch, raises a one-cycle registered
// redirect/flush. Also counts resolved and mispredicted branches (saturating).
//   clk, rst_n          : clock / asynchronous active-low reset
//   valid_d, Branch_d   : decode slot is real / is a conditional branch
//   predict_taken_d     : predictor verdict for the decode instruction
//   PC_d, ImmExt_d      : decode PC and branch offset
//   stall_e             : hold the execute register, no resolution
//   EQ_e                : branch condition for the instruction in execute
//   redirect_valid      : fetch must load redirect_pc (same as flush_fd)
//   redirect_pc         : correct next PC after a mispredict
//   flush_fd            : kill IF/ID contents this cycle
//   branch_count        : resolved branches
//   mispredict_count    : mispredicted branches
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_d,
  input  logic                  Branch_d,
  input  logic                  predict_taken_d,
  input  logic [DATA_WIDTH-1:0] PC_d,
  input  logic [DATA_WIDTH-1:0] ImmExt_d,
  input  logic                  stall_e,
  input  logic                  EQ_e,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush_fd,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  bru_state_t            state_r;
  bru_state_t            next_state_s;

  logic                  v_e_r;
  logic                  br_e_r;
  logic                  pt_e_r;
  logic [DATA_WIDTH-1:0] target_e_r;
  logic [DATA_WIDTH-1:0] pc4_e_r;
  logic [DATA_WIDTH-1:0] redirect_pc_r;

  logic                  resolve_s;
  logic                  mispredict_s;
  logic                  kill_slot_s;
  logic [DATA_WIDTH-1:0] correct_pc_s;

  // Resolution and mispredict detection for the instruction in execute.
  always_comb begin
    resolve_s    = 1'b0;
    mispredict_s = 1'b0;
    correct_pc_s = pc4_e_r;
    kill_slot_s  = 1'b0;
    if (!stall_e && v_e_r && br_e_r) begin
      resolve_s    = 1'b1;
      mispredict_s = (EQ_e != pt_e_r);
    end else begin
      resolve_s    = 1'b0;
      mispredict_s = 1'b0;
    end
    if (EQ_e) begin
      correct_pc_s = target_e_r;
    end else begin
      correct_pc_s = pc4_e_r;
    end
    // The decode slot is wrong-path both in the mispredict cycle and during RECOVER.
    kill_slot_s = mispredict_s || (state_r == RECOVER);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic: RECOVER lasts exactly one cycle, stall or not.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mispredict_s) begin
          next_state_s = RECOVER;
        end else begin
          next_state_s = IDLE;
        end
      end
      RECOVER: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: redirect and flush are a decode of the state register.
  always_comb begin
    redirect_valid = 1'b0;
    flush_fd       = 1'b0;
    case (state_r)
      RECOVER: begin
        redirect_valid = 1'b1;
        flush_fd       = 1'b1;
      end
      IDLE: begin
        redirect_valid = 1'b0;
        flush_fd       = 1'b0;
      end
      default: begin
        redirect_valid = 1'b0;
        flush_fd       = 1'b0;
      end
    endcase
  end

  // Redirect target, latched when IDLE detects a mispredict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc_r <= {DATA_WIDTH{1'b0}};
    end else if ((state_r == IDLE) && mispredict_s) begin
      redirect_pc_r <= correct_pc_s;
    end
  end

  assign redirect_pc = redirect_pc_r;

  // Execute pipeline register: capture decode, insert bubble on kill, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_e_r      <= 1'b0;
      br_e_r     <= 1'b0;
      pt_e_r     <= 1'b0;
      target_e_r <= {DATA_WIDTH{1'b0}};
      pc4_e_r    <= {DATA_WIDTH{1'b0}};
    end else if (!stall_e) begin
      if (kill_slot_s) begin
        v_e_r  <= 1'b0;
        br_e_r <= 1'b0;
        pt_e_r <= 1'b0;
      end else begin
        v_e_r      <= valid_d;
        br_e_r     <= Branch_d;
        pt_e_r     <= predict_taken_d;
        target_e_r <= PC_d + ImmExt_d;
        pc4_e_r    <= PC_d + DATA_WIDTH'(32'd4);
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolve_s),
    .count (branch_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispredict_s),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Scoreboard bench: the driver computes the expected redirect for every
// mispredict from an instruction-level model and queues it; a negedge monitor
// compares the DUT outputs against the queue and the model's counters. A second
// instance with 2-bit counters checks saturation.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  typedef struct {
    bit          v;
    bit          br;
    bit          pt;
    logic [31:0] pc;
    logic [31:0] imm;
  } instr_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_d, Branch_d, predict_taken_d, stall_e, EQ_e;
  logic [31:0] PC_d, ImmExt_d;

  logic        rv_a, fl_a, rv_b, fl_b;
  logic [31:0] rpc_a, rpc_b;
  logic [15:0] bc_a, mc_a;
  logic [1:0]  bc_b, mc_b;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          mon_rv;

  // model state
  instr_t      ex_m;
  int          kill_till = -1;
  int unsigned br_m = 0, mp_m = 0;
  int unsigned br_vis = 0, mp_vis = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  branch_resolve_unit #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .Branch_d(Branch_d),
    .predict_taken_d(predict_taken_d), .PC_d(PC_d), .ImmExt_d(ImmExt_d),
    .stall_e(stall_e), .EQ_e(EQ_e), .redirect_valid(rv_a), .redirect_pc(rpc_a),
    .flush_fd(fl_a), .branch_count(bc_a), .mispredict_count(mc_a)
  );

  branch_resolve_unit #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .Branch_d(Branch_d),
    .predict_taken_d(predict_taken_d), .PC_d(PC_d), .ImmExt_d(ImmExt_d),
    .stall_e(stall_e), .EQ_e(EQ_e), .redirect_valid(rv_b), .redirect_pc(rpc_b),
    .flush_fd(fl_b), .branch_count(bc_b), .mispredict_count(mc_b)
  );

  function automatic int unsigned sat(int unsigned v, int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 32'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One decode/execute cycle: drive inputs and advance the reference model.
  task automatic step(bit v, bit br, bit pt, logic [31:0] pc, logic [31:0] imm,
                      bit st, bit eq);
    instr_t d;
    exp_t   e;
    @(posedge clk); #1;
    br_vis = br_m;
    mp_vis = mp_m;
    valid_d = v; Branch_d = br; predict_taken_d = pt; PC_d = pc; ImmExt_d = imm;
    stall_e = st; EQ_e = eq;
    if (!st && ex_m.v && ex_m.br) begin
      br_m++;
      if (eq != ex_m.pt) begin
        mp_m++;
        e.cyc = cyc + 1;
        e.pc  = eq ? (ex_m.pc + ex_m.imm) : (ex_m.pc + 32'd4);
        exp_q.push_back(e);
        // this decode slot and the next one are wrong-path
        kill_till = cyc + 1;
      end
    end
    if (!st) begin
      if (cyc <= kill_till) begin
        ex_m = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      end else begin
        d = '{v, br, pt, pc, imm};
        ex_m = d;
      end
    end
  endtask

  task automatic nop(bit eq);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, eq);
  endtask

  task automatic model_reset();
    ex_m = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    kill_till = -1;
    br_m = 0; mp_m = 0; br_vis = 0; mp_vis = 0;
    exp_q.delete();
  endtask

  // Scoreboard monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      mon_rv = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("redirect_valid", {63'd0, rv_a}, {63'd0, mon_rv});
      chk("flush_fd", {63'd0, fl_a}, {63'd0, mon_rv});
      chk("redirect_valid_w2", {63'd0, rv_b}, {63'd0, mon_rv});
      if (mon_rv) begin
        chk("redirect_pc", {32'd0, rpc_a}, {32'd0, exp_q[0].pc});
        chk("redirect_pc_w2", {32'd0, rpc_b}, {32'd0, exp_q[0].pc});
        void'(exp_q.pop_front());
      end
      chk("branch_count", {48'd0, bc_a}, 64'(sat(br_vis, 16)));
      chk("mispredict_count", {48'd0, mc_a}, 64'(sat(mp_vis, 16)));
      chk("branch_count_w2", {62'd0, bc_b}, 64'(sat(br_vis, 2)));
      chk("mispredict_count_w2", {62'd0, mc_b}, 64'(sat(mp_vis, 2)));
    end
  end

  initial begin
    rst_n = 1'b0;
    valid_d = 1'b0; Branch_d = 1'b0; predict_taken_d = 1'b0;
    PC_d = 32'h0; ImmExt_d = 32'h0; stall_e = 1'b0; EQ_e = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_redirect_valid", {63'd0, rv_a}, 64'd0);
    chk("reset_flush_fd", {63'd0, fl_a}, 64'd0);
    chk("reset_redirect_pc", {32'd0, rpc_a}, 64'd0);
    chk("reset_branch_count", {48'd0, bc_a}, 64'd0);
    chk("reset_mispredict_count", {48'd0, mc_a}, 64'd0);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // forward branch, predicted not taken, not taken
    step(1'b1, 1'b1, 1'b0, 32'h100, 32'h20, 1'b0, 1'b0);
    nop(1'b0);
    nop(1'b0);
    @(negedge clk);
    chk("tp1_branch_count", {48'd0, bc_a}, 64'd1);
    chk("tp1_mispredict_count", {48'd0, mc_a}, 64'd0);

    // same branch taken: redirect to 0x120, younger branch must not resolve
    step(1'b1, 1'b1, 1'b0, 32'h100, 32'h20, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h104, 32'h8, 1'b0, 1'b1);
    nop(1'b1);
    nop(1'b1);
    nop(1'b1);
    @(negedge clk);
    chk("tp2_branch_count", {48'd0, bc_a}, 64'd2);
    chk("tp2_mispredict_count", {48'd0, mc_a}, 64'd1);

    // backward branch predicted taken, not taken: redirect to 0x204
    step(1'b1, 1'b1, 1'b1, 32'h200, 32'hFFFF_FFF0, 1'b0, 1'b0);
    nop(1'b0);
    nop(1'b0);

    // branch held in execute by a 3-cycle stall, then resolves once
    step(1'b1, 1'b1, 1'b0, 32'h400, 32'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    nop(1'b1);
    nop(1'b0);
    nop(1'b0);

    // five more mispredicts: 2-bit counters stick at 3
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'h1000 + 32'(i * 64), 32'h10, 1'b0, 1'b0);
      nop(1'b0);
      nop(1'b0);
    end
    @(negedge clk);
    chk("sat_mispredict_w2", {62'd0, mc_b}, 64'd3);

    // reset asserted in the middle of RECOVER
    step(1'b1, 1'b1, 1'b0, 32'h300, 32'h40, 1'b0, 1'b0);
    nop(1'b1);
    @(posedge clk); #1;
    br_vis = br_m;
    mp_vis = mp_m;
    valid_d = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_redirect_valid", {63'd0, rv_a}, 64'd0);
    chk("rst_mid_flush_fd", {63'd0, fl_a}, 64'd0);
    chk("rst_mid_redirect_pc", {32'd0, rpc_a}, 64'd0);
    chk("rst_mid_branch_count", {48'd0, bc_a}, 64'd0);
    chk("rst_mid_mispredict_count", {48'd0, mc_a}, 64'd0);
    model_reset();
    @(negedge clk); #2;
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 8), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 4) == 0), $urandom_range(0, 1));
    end
    repeat (4) nop(1'b0);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
